// File: rtl/time_field_counter_pkg.sv
// Shared types and default field ranges for the time field counters.
// Combinational only; no state, no backpressure.
package time_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  localparam int SEC_LO   = 0;
  localparam int SEC_HI   = 59;
  localparam int MINUTE_LO = 0;
  localparam int MINUTE_HI = 59;
  localparam int HOUR_LO  = 0;
  localparam int HOUR_HI  = 23;
  localparam int DAY_LO   = 1;
  localparam int DAY_HI   = 31;
  localparam int MONTH_LO = 1;
  localparam int MONTH_HI = 12;

  localparam int DEF_REPEAT_DELAY  = 16;
  localparam int DEF_REPEAT_PERIOD = 4;

endpackage

// File: rtl/time_field_counter_if.sv
// Control and status bundle of one time field counter.
// No handshake: strobes and levels are sampled every clk edge.
interface time_field_counter_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic             set;
  logic             inc;
  logic             dec;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] max_limit;
  logic [WIDTH-1:0] value;
  logic             carry_out;

  modport master (
    output tick, set, inc, dec, load, load_value, max_limit,
    input  value, carry_out
  );

  modport slave (
    input  tick, set, inc, dec, load, load_value, max_limit,
    output value, carry_out
  );
endinterface

// File: rtl/time_field_counter_button_repeat.sv
// Held-button auto-repeat: step pulse on press, again after REPEAT_DELAY, then every REPEAT_PERIOD.
// Pulses are combinational in the press cycle; no backpressure.
module button_repeat
  import time_pkg::*;
#(
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic inc,
  input  logic dec,
  output logic step_up,
  output logic step_down
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  rpt_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          dir_up, dir_up_nxt;
  logic          press, step, step_due;

  assign press   = set & (inc ^ dec);
  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RPT_IDLE;
      cnt    <= '0;
      dir_up <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dir_up <= dir_up_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_up_nxt = dir_up;
    step       = 1'b0;
    step_due   = (state == RPT_DELAY) ? (cnt_inc == CW'(REPEAT_DELAY))
                                      : (cnt_inc == CW'(REPEAT_PERIOD));
    if (!press) begin
      state_nxt = RPT_IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        RPT_IDLE: begin
          step       = 1'b1;
          dir_up_nxt = inc;
          state_nxt  = RPT_DELAY;
          cnt_nxt    = '0;
        end
        RPT_DELAY, RPT_REPEAT: begin
          // A direction change drops back to idle; the new direction steps next cycle.
          if (inc != dir_up) begin
            state_nxt = RPT_IDLE;
            cnt_nxt   = '0;
          end else if (step_due) begin
            step      = 1'b1;
            state_nxt = RPT_REPEAT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = RPT_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
    step_up   = step & dir_up_nxt;
    step_down = step & ~dir_up_nxt;
  end

endmodule

// File: rtl/time_field_counter.sv
// Wrapping time field (sec/min/hour/day/month) with load, runtime limit clamp, adjust and carry.
// Value and carry registered, 1-cycle latency; no backpressure.
module time_field_counter
  import time_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int MIN_VALUE     = SEC_LO,
  parameter int MAX_VALUE     = SEC_HI,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 reset,
  time_field_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] eff_max, load_clamped, value_q, value_nxt;
  logic             carry_q, carry_nxt;
  logic             step_up, step_down;

  button_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat (
    .clk       (clk),
    .reset     (reset),
    .set       (bus.set),
    .inc       (bus.inc),
    .dec       (bus.dec),
    .step_up   (step_up),
    .step_down (step_down)
  );

  always_comb begin
    if (bus.max_limit < MIN_V)      eff_max = MIN_V;
    else if (bus.max_limit < MAX_V) eff_max = bus.max_limit;
    else                            eff_max = MAX_V;
  end

  assign load_clamped = (bus.load_value < MIN_V)   ? MIN_V   :
                        (bus.load_value > eff_max) ? eff_max : bus.load_value;

  // value never exceeds MAX_V < 2**WIDTH here, so +1 cannot overflow.
  always_comb begin
    value_nxt = value_q;
    carry_nxt = 1'b0;
    if (bus.load) begin
      value_nxt = load_clamped;
    end else if (value_q > eff_max) begin
      value_nxt = eff_max;
    end else if (step_up) begin
      value_nxt = (value_q >= eff_max) ? MIN_V : value_q + WIDTH'(1);
    end else if (step_down) begin
      value_nxt = (value_q <= MIN_V) ? eff_max : value_q - WIDTH'(1);
    end else if (bus.tick && !bus.set) begin
      if (value_q >= eff_max) begin
        value_nxt = MIN_V;
        carry_nxt = 1'b1;
      end else begin
        value_nxt = value_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= MIN_V;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_nxt;
      carry_q <= carry_nxt;
    end
  end

  assign bus.value     = value_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_time_field_counter.sv
// Bench for time_field_counter: directed vector table, hand sequences, randomized run vs reference model.
module tb_time_field_counter;

  localparam int W  = 8;
  localparam int RD = 4;
  localparam int RP = 2;

  typedef struct {
    int tick; int set; int inc; int dec; int load; int lv; int ml;
  } in_t;

  typedef struct {
    in_t in; int ev; int ec;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  time_field_counter_if #(.WIDTH(W)) ifa ();
  time_field_counter_if #(.WIDTH(W)) ifb ();

  time_field_counter #(
    .WIDTH(W), .MIN_VALUE(0), .MAX_VALUE(59), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));

  time_field_counter #(
    .WIDTH(W), .MIN_VALUE(1), .MAX_VALUE(31), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: m_age is cycles since the current press began, -1 when not pressed.
  int m_lo[2] = '{0, 1};
  int m_hi[2] = '{59, 31};
  int m_val[2];
  int m_age[2];
  int m_up[2];
  int m_carry[2];

  function automatic in_t mkin(int t, int s, int i, int d, int l, int lv, int ml);
    in_t r;
    r.tick = t; r.set = s; r.inc = i; r.dec = d; r.load = l; r.lv = lv; r.ml = ml;
    return r;
  endfunction

  function automatic vec_t mkv(in_t x, int ev, int ec);
    vec_t r;
    r.in = x; r.ev = ev; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input int id, input in_t x);
    if (id == 0) begin
      ifa.tick = x.tick[0]; ifa.set = x.set[0]; ifa.inc = x.inc[0]; ifa.dec = x.dec[0];
      ifa.load = x.load[0]; ifa.load_value = W'(x.lv); ifa.max_limit = W'(x.ml);
    end else begin
      ifb.tick = x.tick[0]; ifb.set = x.set[0]; ifb.inc = x.inc[0]; ifb.dec = x.dec[0];
      ifb.load = x.load[0]; ifb.load_value = W'(x.lv); ifb.max_limit = W'(x.ml);
    end
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_val[id] = m_lo[id]; m_age[id] = -1; m_up[id] = 0; m_carry[id] = 0;
    end
  endtask

  task automatic model_edge(input int id, input in_t x);
    int  lo, hi, eff;
    bit  press, step, up_req;
    lo = m_lo[id]; hi = m_hi[id];
    eff = (x.ml < lo) ? lo : ((x.ml < hi) ? x.ml : hi);
    up_req = (x.inc != 0);
    press  = (x.set != 0) && ((x.inc != 0) != (x.dec != 0));
    step   = 1'b0;
    if (!press) begin
      m_age[id] = -1;
    end else if (m_age[id] >= 0 && up_req == (m_up[id] != 0)) begin
      m_age[id]++;
      step = (m_age[id] >= RD) && ((m_age[id] - RD) % RP == 0);
    end else if (m_age[id] >= 0) begin
      m_age[id] = -1;
    end else begin
      m_age[id] = 0; m_up[id] = int'(up_req); step = 1'b1;
    end
    m_carry[id] = 0;
    if (x.load != 0) begin
      m_val[id] = (x.lv < lo) ? lo : ((x.lv > eff) ? eff : x.lv);
    end else if (m_val[id] > eff) begin
      m_val[id] = eff;
    end else if (step) begin
      if (m_up[id] != 0) m_val[id] = (m_val[id] >= eff) ? lo : m_val[id] + 1;
      else               m_val[id] = (m_val[id] <= lo) ? eff : m_val[id] - 1;
    end else if (x.tick != 0 && x.set == 0) begin
      if (m_val[id] >= eff) begin m_val[id] = lo; m_carry[id] = 1; end
      else m_val[id] = m_val[id] + 1;
    end
  endtask

  task automatic cyc(input in_t a, input in_t b);
    drive(0, a);
    drive(1, b);
    @(posedge clk);
    model_edge(0, a);
    model_edge(1, b);
    #1;
  endtask

  initial begin
    in_t  idle_a, idle_b, a, b;
    in_t  cur[2];
    vec_t vecs[$];
    int   inc_exp[10] = '{11, 11, 11, 11, 12, 12, 13, 13, 14, 14};
    int   carry_seen;

    idle_a = mkin(0, 0, 0, 0, 0, 0, 59);
    idle_b = mkin(0, 0, 0, 0, 0, 0, 31);
    drive(0, idle_a);
    drive(1, idle_b);

    // Reset state
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("reset value a", int'(ifa.value), 0);
    chk("reset carry a", int'(ifa.carry_out), 0);
    chk("reset value b", int'(ifb.value), 1);
    chk("reset carry b", int'(ifb.carry_out), 0);
    @(negedge clk) reset = 1'b1;

    // 59 ticks to the top, 60th wraps with a single carry pulse
    carry_seen = 0;
    for (int i = 0; i < 59; i++) begin
      cyc(mkin(1, 0, 0, 0, 0, 0, 59), idle_b);
      carry_seen += int'(ifa.carry_out);
    end
    chk("59 ticks value", int'(ifa.value), 59);
    chk("59 ticks carry count", carry_seen, 0);
    cyc(mkin(1, 0, 0, 0, 0, 0, 59), idle_b);
    chk("60th tick value", int'(ifa.value), 0);
    chk("60th tick carry", int'(ifa.carry_out), 1);
    cyc(idle_a, idle_b);
    chk("carry one cycle", int'(ifa.carry_out), 0);

    // Directed vector table on the 0..59 field
    vecs.push_back(mkv(mkin(0, 0, 0, 0, 1, 10, 59), 10, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mkv(mkin(0, 1, 1, 0, 0, 0, 59), inc_exp[i], 0));
    vecs.push_back(mkv(mkin(0, 1, 0, 0, 0, 0, 59), 14, 0));
    vecs.push_back(mkv(mkin(0, 0, 0, 0, 1, 0, 59), 0, 0));
    vecs.push_back(mkv(mkin(0, 1, 0, 1, 0, 0, 59), 59, 0));
    vecs.push_back(mkv(mkin(1, 1, 0, 0, 0, 0, 59), 59, 0));
    vecs.push_back(mkv(mkin(0, 1, 1, 1, 0, 0, 59), 59, 0));
    vecs.push_back(mkv(mkin(0, 0, 0, 0, 1, 75, 59), 59, 0));
    vecs.push_back(mkv(mkin(1, 0, 0, 0, 0, 0, 59), 0, 1));
    vecs.push_back(mkv(mkin(0, 0, 0, 0, 0, 0, 59), 0, 0));
    vecs.push_back(mkv(mkin(0, 0, 1, 0, 0, 0, 59), 0, 0));
    vecs.push_back(mkv(mkin(1, 0, 0, 0, 0, 0, 59), 1, 0));
    vecs.push_back(mkv(mkin(1, 0, 0, 0, 0, 0, 0), 0, 0));
    vecs.push_back(mkv(mkin(1, 0, 0, 0, 0, 0, 0), 0, 1));
    vecs.push_back(mkv(mkin(0, 0, 0, 0, 0, 0, 59), 0, 0));
    foreach (vecs[i]) begin
      cyc(vecs[i].in, idle_b);
      chk($sformatf("vec%0d value", i), int'(ifa.value), vecs[i].ev);
      chk($sformatf("vec%0d carry", i), int'(ifa.carry_out), vecs[i].ec);
    end

    // Day field 1..31 with a runtime month limit
    cyc(idle_a, mkin(0, 0, 0, 0, 1, 28, 28));
    chk("day load 28", int'(ifb.value), 28);
    cyc(idle_a, mkin(1, 0, 0, 0, 0, 0, 28));
    chk("day wrap value", int'(ifb.value), 1);
    chk("day wrap carry", int'(ifb.carry_out), 1);
    cyc(idle_a, mkin(0, 0, 0, 0, 1, 30, 31));
    chk("day load 30", int'(ifb.value), 30);
    chk("day load carry", int'(ifb.carry_out), 0);
    cyc(idle_a, mkin(0, 0, 0, 0, 0, 0, 28));
    chk("day clamp value", int'(ifb.value), 28);
    chk("day clamp carry", int'(ifb.carry_out), 0);
    cyc(idle_a, mkin(0, 0, 0, 0, 1, 5, 0));
    chk("day load limit 0", int'(ifb.value), 1);
    cyc(idle_a, idle_b);

    // Async reset while auto-repeating, then button still held on release
    a = mkin(0, 1, 1, 0, 0, 0, 59);
    cyc(mkin(0, 0, 0, 0, 1, 10, 59), idle_b);
    for (int i = 0; i < 7; i++) cyc(a, idle_b);
    chk("repeat before reset", int'(ifa.value), 13);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async reset value a", int'(ifa.value), 0);
    chk("async reset carry a", int'(ifa.carry_out), 0);
    chk("async reset value b", int'(ifb.value), 1);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(a, idle_b);
      chk($sformatf("held after reset c%0d", i), int'(ifa.value), (i < 4) ? 1 : 2);
    end
    cyc(idle_a, idle_b);

    // Randomized run against the reference model, sticky buttons for long presses
    cur[0] = idle_a;
    cur[1] = idle_b;
    for (int n = 0; n < 1500; n++) begin
      for (int id = 0; id < 2; id++) begin
        cur[id].tick = ($urandom_range(0, 2) == 0) ? 1 : 0;
        if ($urandom_range(0, 7) == 0) cur[id].set = 1 - cur[id].set;
        if ($urandom_range(0, 5) == 0) cur[id].inc = int'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) cur[id].dec = int'($urandom_range(0, 1));
        cur[id].load = ($urandom_range(0, 19) == 0) ? 1 : 0;
        cur[id].lv   = int'($urandom_range(0, 255));
        if ($urandom_range(0, 24) == 0)
          cur[id].ml = int'((id == 0) ? $urandom_range(0, 70) : $urandom_range(0, 40));
      end
      a = cur[0];
      b = cur[1];
      cyc(a, b);
      chk($sformatf("rand%0d value a", n), int'(ifa.value), m_val[0]);
      chk($sformatf("rand%0d carry a", n), int'(ifa.carry_out), m_carry[0]);
      chk($sformatf("rand%0d value b", n), int'(ifb.value), m_val[1]);
      chk($sformatf("rand%0d carry b", n), int'(ifb.carry_out), m_carry[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
